// File: rtl/piece_evt_pkg.sv
// Shared types for the piece event scheduler: FSM states, grid geometry,
// the event record and a lowest-set-bit helper.
package piece_evt_pkg;

  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int GRID_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             pressed;
  } evt_t;

  // Lowest set bit of a row; returns 0 for an empty row.
  function automatic logic [COL_W-1:0] lowest_bit(input logic [7:0] v);
    lowest_bit = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = COL_W'(i);
    end
  endfunction

endpackage

// File: rtl/piece_debouncer.sv
// Periodic whole-grid sampler and debouncer: the stable grid only follows a
// snapshot after DEBOUNCE_TICKS consecutive identical samples.
module piece_debouncer
  import piece_evt_pkg::*;
#(
  parameter int TICK_DIV       = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [GRID_W-1:0] i_grid,
  output logic [GRID_W-1:0] o_stable,
  output logic              o_stable_upd
);

  localparam logic [3:0] STAB_MAX = 4'(DEBOUNCE_TICKS - 1);

  logic [TICK_DIV-1:0] r_tick;
  logic [GRID_W-1:0]   r_prev;
  logic [GRID_W-1:0]   r_stable;
  logic [3:0]          r_stab;
  logic                r_upd;
  logic                w_wrap;

  assign w_wrap       = &r_tick;
  assign o_stable     = r_stable;
  assign o_stable_upd = r_upd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick   <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_stab   <= '0;
      r_upd    <= 1'b0;
    end else begin
      r_tick <= r_tick + 1'b1;
      r_upd  <= 1'b0;
      if (w_wrap) begin
        if (i_grid != r_prev) begin
          r_prev <= i_grid;
          r_stab <= '0;
        end else if (r_stab != STAB_MAX) begin
          // Commit exactly once, on the sample that reaches saturation.
          r_stab <= r_stab + 4'd1;
          if (r_stab + 4'd1 == STAB_MAX) begin
            r_stable <= r_prev;
            r_upd    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/piece_event_scheduler.sv
// Turns debounced grid changes into single press/release events, round-robin
// across rows. Optional event counter enabled by macro PIECE_EVT_COUNT_EN.
// Handshake: o_evt_valid stays high with row/col/pressed frozen until a cycle
// with i_evt_ready high; the event is consumed on that clock edge.
module piece_event_scheduler
  import piece_evt_pkg::*;
#(
  parameter int TICK_DIV       = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_pieces0,
  input  logic [7:0]       i_pieces1,
  input  logic [7:0]       i_pieces2,
  input  logic [7:0]       i_pieces3,
  input  logic [7:0]       i_pieces4,
  input  logic [7:0]       i_pieces5,
  input  logic [7:0]       i_pieces6,
  input  logic [7:0]       i_pieces7,
  output logic             o_evt_valid,
  input  logic             i_evt_ready,
  output logic [ROW_W-1:0] o_evt_row,
  output logic [COL_W-1:0] o_evt_col,
  output logic             o_evt_pressed,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
`ifdef PIECE_EVT_COUNT_EN
  ,
  output logic [15:0]      o_evt_count
`endif
);

  logic [GRID_W-1:0] w_grid;
  logic [GRID_W-1:0] w_stable;
  logic              w_stable_upd;
  logic [GRID_W-1:0] w_diff;
  logic [7:0]        w_row_diff;
  logic [COL_W-1:0]  w_col;

  state_t            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_rp, w_rp_nxt;
  logic [2:0]        r_empty, w_empty_nxt;
  evt_t              r_evt, w_evt_nxt;
  logic [GRID_W-1:0] r_rep;
  logic              w_accept;

  assign w_grid = {i_pieces7, i_pieces6, i_pieces5, i_pieces4,
                   i_pieces3, i_pieces2, i_pieces1, i_pieces0};

  piece_debouncer #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_grid       (w_grid),
    .o_stable     (w_stable),
    .o_stable_upd (w_stable_upd)
  );

  assign w_diff     = w_stable ^ r_rep;
  assign w_row_diff = w_diff[{r_rp, 3'b000} +: 8];
  assign w_col      = lowest_bit(w_row_diff);

  always_comb begin
    w_state_nxt = r_state;
    w_rp_nxt    = r_rp;
    w_empty_nxt = r_empty;
    w_evt_nxt   = r_evt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_diff) begin
          w_state_nxt = SCAN;
          w_empty_nxt = '0;
        end
      end
      SCAN: begin
        if (|w_row_diff) begin
          w_evt_nxt.row     = r_rp;
          w_evt_nxt.col     = w_col;
          w_evt_nxt.pressed = w_stable[{r_rp, w_col}];
          w_state_nxt       = OFFER;
        end else begin
          w_rp_nxt = r_rp + 1'b1;
          // A fresh snapshot may have touched rows already passed: restart the pass.
          if (w_stable_upd) begin
            w_empty_nxt = '0;
          end else if (r_empty == 3'd7) begin
            w_state_nxt = IDLE;
            w_empty_nxt = '0;
          end else begin
            w_empty_nxt = r_empty + 3'd1;
          end
        end
      end
      OFFER: begin
        if (i_evt_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
          w_empty_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_rp    <= '0;
      r_empty <= '0;
      r_evt   <= '0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rp    <= w_rp_nxt;
      r_empty <= w_empty_nxt;
      r_evt   <= w_evt_nxt;
      if (w_accept) r_rep[{r_evt.row, r_evt.col}] <= r_evt.pressed;
    end
  end

`ifdef PIECE_EVT_COUNT_EN
  logic [15:0] r_evt_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_evt_count <= '0;
    else if (w_accept) r_evt_count <= r_evt_count + 16'd1;
  end

  assign o_evt_count = r_evt_count;
`endif

  assign o_evt_valid   = (r_state == OFFER);
  assign o_evt_row     = r_evt.row;
  assign o_evt_col     = r_evt.col;
  assign o_evt_pressed = r_evt.pressed;
  assign o_busy        = (r_state != IDLE);
  assign o_dbg_state   = r_state;

endmodule
